// File: rtl/clint_timer_master_pkg.sv
// clint_timer_master_pkg: opcodes, FSM states and mtime/mtimecmp bus addresses for clint_timer_master.
`ifndef MTIME_ADDR_LOW
`define MTIME_ADDR_LOW 32'h0200_BFF8
`endif
`ifndef MTIME_ADDR_HIGH
`define MTIME_ADDR_HIGH 32'h0200_BFFC
`endif
`ifndef MTIMECMP_ADDR_LOW
`define MTIMECMP_ADDR_LOW 32'h0200_4000
`endif
`ifndef MTIMECMP_ADDR_HIGH
`define MTIMECMP_ADDR_HIGH 32'h0200_4004
`endif

package clint_timer_master_pkg;
  typedef enum logic [1:0] {
    CMD_RD_TIME = 2'd0,
    CMD_WR_CMP  = 2'd1,
    CMD_WR_TIME = 2'd2,
    CMD_RD_CMP  = 2'd3
  } cmd_op_e;
  typedef enum logic [3:0] {
    IDLE, RT_HI1, RT_LO, RT_HI2, RC_LO, RC_HI,
    WC_LO_MAX, WC_HI, WC_LO, WT_LO0, WT_HI, WT_LO, RESP
  } state_e;
  localparam logic [31:0] MTIME_LO_A = `MTIME_ADDR_LOW;
  localparam logic [31:0] MTIME_HI_A = `MTIME_ADDR_HIGH;
  localparam logic [31:0] CMP_LO_A   = `MTIMECMP_ADDR_LOW;
  localparam logic [31:0] CMP_HI_A   = `MTIMECMP_ADDR_HIGH;
endpackage

// File: rtl/clint_timer_master.sv
// clint_timer_master: sequences 64-bit timer commands into 32-bit mtime/mtimecmp bus beats.
// Optional CLINT_TIMER_IRQ_MASK_EN registers timer_irq_o and masks it while mtimecmp is rewritten.
module clint_timer_master
  import clint_timer_master_pkg::*;
#(
  parameter int MAX_RETRY = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [1:0]  cmd_op_i,
  input  logic [63:0] cmd_wdata_i,
  output logic        rsp_valid_o,
  output logic [63:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic [31:0] bus_addr_o,
  output logic        bus_write_valid_o,
  output logic [31:0] bus_wdata_o,
  input  logic [31:0] bus_rdata_i,
  input  logic        mtime_ge_i,
  output logic        timer_irq_o
);
  localparam int RW = $clog2(MAX_RETRY + 2);
  state_e st, nxt;
  logic [63:0] wdata;
  logic [31:0] hi1, lo;
  logic [RW-1:0] retries;
  logic accept, hi_eq, give_up;
  assign cmd_ready_o = st == IDLE && !rst;
  assign accept = cmd_valid_i && cmd_ready_o;
  assign rsp_valid_o = st == RESP;
  assign hi_eq = bus_rdata_i == hi1;
  assign give_up = retries == RW'(MAX_RETRY);
  always_ff @(posedge clk) st <= rst ? IDLE : nxt;
  always_comb begin
    nxt = st;
    case (st)
      IDLE:
        if (accept)
          case (cmd_op_e'(cmd_op_i))
            CMD_RD_TIME: nxt = RT_HI1;
            CMD_WR_CMP:  nxt = WC_LO_MAX;
            CMD_WR_TIME: nxt = WT_LO0;
            default:     nxt = RC_LO;
          endcase
      RT_HI1:    nxt = RT_LO;
      RT_LO:     nxt = RT_HI2;
      RT_HI2:    nxt = (hi_eq || give_up) ? RESP : RT_LO;
      RC_LO:     nxt = RC_HI;
      WC_LO_MAX: nxt = WC_HI;
      WC_HI:     nxt = WC_LO;
      WT_LO0:    nxt = WT_HI;
      WT_HI:     nxt = WT_LO;
      RC_HI, WC_LO, WT_LO: nxt = RESP;
      default:   nxt = IDLE;
    endcase
  end
  always_comb begin
    bus_addr_o = '0;
    bus_write_valid_o = 1'b0;
    bus_wdata_o = '0;
    case (st)
      RT_HI1, RT_HI2: bus_addr_o = MTIME_HI_A;
      RT_LO:          bus_addr_o = MTIME_LO_A;
      RC_LO:          bus_addr_o = CMP_LO_A;
      RC_HI:          bus_addr_o = CMP_HI_A;
      WC_LO_MAX: begin
        bus_addr_o = CMP_LO_A;
        bus_write_valid_o = 1'b1;
        bus_wdata_o = 32'hFFFF_FFFF;
      end
      WC_HI: begin
        bus_addr_o = CMP_HI_A;
        bus_write_valid_o = 1'b1;
        bus_wdata_o = wdata[63:32];
      end
      WC_LO: begin
        bus_addr_o = CMP_LO_A;
        bus_write_valid_o = 1'b1;
        bus_wdata_o = wdata[31:0];
      end
      WT_LO0: begin
        bus_addr_o = MTIME_LO_A;
        bus_write_valid_o = 1'b1;
      end
      WT_HI: begin
        bus_addr_o = MTIME_HI_A;
        bus_write_valid_o = 1'b1;
        bus_wdata_o = wdata[63:32];
      end
      WT_LO: begin
        bus_addr_o = MTIME_LO_A;
        bus_write_valid_o = 1'b1;
        bus_wdata_o = wdata[31:0];
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wdata <= '0;
      hi1 <= '0;
      lo <= '0;
      retries <= '0;
      rsp_rdata_o <= '0;
      rsp_err_o <= 1'b0;
    end else
      case (st)
        IDLE:
          if (accept) begin
            wdata <= cmd_wdata_i;
            retries <= '0;
          end
        RT_HI1: hi1 <= bus_rdata_i;
        RT_LO, RC_LO: lo <= bus_rdata_i;
        RT_HI2:
          if (hi_eq || give_up) begin
            rsp_rdata_o <= {bus_rdata_i, lo};
            rsp_err_o <= !hi_eq;
          end else begin
            hi1 <= bus_rdata_i;
            retries <= retries + 1'b1;
          end
        RC_HI: begin
          rsp_rdata_o <= {bus_rdata_i, lo};
          rsp_err_o <= 1'b0;
        end
        WC_LO, WT_LO: begin
          rsp_rdata_o <= '0;
          rsp_err_o <= 1'b0;
        end
        default: ;
      endcase
  end
`ifdef CLINT_TIMER_IRQ_MASK_EN
  logic irq_q, post_wc;
  always_ff @(posedge clk) begin
    irq_q <= !rst && mtime_ge_i;
    post_wc <= !rst && st == WC_LO;
  end
  // A half-written mtimecmp can compare low against mtime; hold the level off until it settles.
  assign timer_irq_o = irq_q && !post_wc && !(st inside {WC_LO_MAX, WC_HI, WC_LO});
`else
  assign timer_irq_o = mtime_ge_i;
`endif
endmodule

// File: tb/tb_clint_timer_master.sv
// tb_clint_timer_master: directed scoreboard bench for clint_timer_master with a behavioural mtime peripheral.
module tb_clint_timer_master;
  import clint_timer_master_pkg::*;
  logic clk = 1'b0, rst = 1'b1;
  logic cmd_valid_i = 1'b0, cmd_ready_o;
  logic [1:0] cmd_op_i = 2'd0;
  logic [63:0] cmd_wdata_i = '0, rsp_rdata_o;
  logic rsp_valid_o, rsp_err_o, bus_write_valid_o;
  logic [31:0] bus_addr_o, bus_wdata_o, bus_rdata_i = '0;
  logic mtime_ge_i = 1'b0, timer_irq_o;
  int total = 0, bad = 0, cyc = 0, acc_cyc = 0, rsp_cyc = 0, nrsp = 0;
  int mode = 0, hi_reads = 0, lo_reads = 0;
  logic [63:0] mt = '0, cmp = '0;
  logic [31:0] last_wr = '0;
  logic irq_chk = 1'b0, irq_exp = 1'b0;
  logic [31:0] exp_rd[$];
  logic [63:0] exp_wr[$];
  logic [64:0] exp_rsp[$];

  clint_timer_master dut (
    .clk(clk), .rst(rst), .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_op_i(cmd_op_i), .cmd_wdata_i(cmd_wdata_i), .rsp_valid_o(rsp_valid_o),
    .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o), .bus_addr_o(bus_addr_o),
    .bus_write_valid_o(bus_write_valid_o), .bus_wdata_o(bus_wdata_o),
    .bus_rdata_i(bus_rdata_i), .mtime_ge_i(mtime_ge_i), .timer_irq_o(timer_irq_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [64:0] got, input logic [64:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // One cycle: drive read data for the current beat, score beats/responses, update the model.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (bus_addr_o != 0 && !bus_write_valid_o) begin
      if (exp_rd.size() == 0) chk("rd_extra", 65'(bus_addr_o), 65'(0));
      else chk("rd_addr", 65'(bus_addr_o), 65'(exp_rd.pop_front()));
      if (bus_addr_o == MTIME_HI_A) begin
        bus_rdata_i = mode == 0 ? mt[63:32] : mode == 1 ? (hi_reads == 0 ? 32'd7 : 32'd8) : 32'(hi_reads);
        hi_reads++;
      end else if (bus_addr_o == MTIME_LO_A) begin
        bus_rdata_i = mode == 0 ? mt[31:0] : mode == 1 ? (lo_reads == 0 ? 32'hFFFF_FFFE : 32'd3) : 32'hABCD;
        lo_reads++;
      end else bus_rdata_i = bus_addr_o == CMP_LO_A ? cmp[31:0] : bus_addr_o == CMP_HI_A ? cmp[63:32] : 32'd0;
    end
    if (bus_write_valid_o) begin
      if (exp_wr.size() == 0) chk("wr_extra", 65'({bus_addr_o, bus_wdata_o}), 65'(0));
      else chk("wr_beat", 65'({bus_addr_o, bus_wdata_o}), 65'(exp_wr.pop_front()));
      last_wr = bus_addr_o;
      if (bus_addr_o == CMP_LO_A) cmp[31:0] = bus_wdata_o;
      if (bus_addr_o == CMP_HI_A) cmp[63:32] = bus_wdata_o;
      if (bus_addr_o == MTIME_LO_A) mt[31:0] = bus_wdata_o;
      if (bus_addr_o == MTIME_HI_A) mt[63:32] = bus_wdata_o;
    end
    if (rsp_valid_o) begin
      if (exp_rsp.size() == 0) chk("rsp_extra", {rsp_err_o, rsp_rdata_o}, 65'(0));
      else chk("rsp", {rsp_err_o, rsp_rdata_o}, exp_rsp.pop_front());
      rsp_cyc = cyc;
      nrsp++;
    end
    if (irq_chk) chk("irq_masked", 65'(timer_irq_o), 65'(irq_exp));
  endtask

  task automatic do_cmd(input logic [1:0] op, input logic [63:0] wd, input logic hold);
    cmd_op_i = op;
    cmd_wdata_i = wd;
    cmd_valid_i = 1'b1;
    for (int i = 0; i < 20 && !cmd_ready_o; i++) step();
    chk("accept", 65'(cmd_ready_o), 65'(1));
    acc_cyc = cyc;
    step();
    if (!hold) cmd_valid_i = 1'b0;
  endtask

  task automatic wait_rsp();
    int n0 = nrsp;
    for (int i = 0; i < 40 && nrsp == n0; i++) step();
    chk("rsp_seen", 65'(nrsp), 65'(n0 + 1));
  endtask

  task automatic set_mode(input int m);
    mode = m;
    hi_reads = 0;
    lo_reads = 0;
  endtask

  initial begin
    repeat (3) step();
    chk("rst_ready", 65'(cmd_ready_o), 65'(0));
    chk("rst_addr", 65'(bus_addr_o), 65'(0));
    chk("rst_rsp", {rsp_valid_o, rsp_rdata_o}, 65'(0));
    chk("rst_wr", 65'(bus_write_valid_o), 65'(0));
    rst = 1'b0;
    step();
    chk("idle_ready", 65'(cmd_ready_o), 65'(1));
    // reset while WC_HI is on the bus
    exp_wr.push_back({CMP_LO_A, 32'hFFFF_FFFF});
    exp_wr.push_back({CMP_HI_A, 32'hDEAD_BEEF});
    exp_wr.push_back({CMP_LO_A, 32'h0000_0001});
    do_cmd(2'(CMD_WR_CMP), 64'hDEAD_BEEF_0000_0001, 1'b0);
    for (int i = 0; i < 8 && last_wr != CMP_HI_A; i++) step();
    chk("saw_wc_hi", 65'(last_wr), 65'(CMP_HI_A));
    rst = 1'b1;
    step();
    chk("abort_wr", 65'(bus_write_valid_o), 65'(0));
    chk("abort_rsp", 65'(rsp_valid_o), 65'(0));
    exp_wr.delete();
    rst = 1'b0;
    step();
    chk("post_rst_ready", 65'(cmd_ready_o), 65'(1));
    step();
    chk("post_rst_addr", 65'(bus_addr_o), 65'(0));
    // coherent read, no carry
    set_mode(0);
    mt = 64'h0000_0005_0000_1000;
    exp_rd.push_back(MTIME_HI_A); exp_rd.push_back(MTIME_LO_A); exp_rd.push_back(MTIME_HI_A);
    exp_rsp.push_back({1'b0, 64'h0000_0005_0000_1000});
    do_cmd(2'(CMD_RD_TIME), 64'd0, 1'b0);
    wait_rsp();
    chk("rd_time_lat", 65'(rsp_cyc - acc_cyc), 65'(4));
    step();
    chk("rsp_hold", {rsp_err_o, rsp_rdata_o}, {1'b0, 64'h0000_0005_0000_1000});
    // high word rolls 7 -> 8 between beats: one retry
    set_mode(1);
    exp_rd.push_back(MTIME_HI_A);
    for (int i = 0; i < 2; i++) begin exp_rd.push_back(MTIME_LO_A); exp_rd.push_back(MTIME_HI_A); end
    exp_rsp.push_back({1'b0, 32'd8, 32'd3});
    do_cmd(2'(CMD_RD_TIME), 64'd0, 1'b0);
    wait_rsp();
    chk("roll_rd_count", 65'(hi_reads + lo_reads), 65'(5));
    // high word changes on every read: give up after MAX_RETRY retries
    set_mode(2);
    exp_rd.push_back(MTIME_HI_A);
    for (int i = 0; i < 4; i++) begin exp_rd.push_back(MTIME_LO_A); exp_rd.push_back(MTIME_HI_A); end
    exp_rsp.push_back({1'b1, 32'd4, 32'hABCD});
    do_cmd(2'(CMD_RD_TIME), 64'd0, 1'b0);
    wait_rsp();
    chk("churn_left", 65'(exp_rd.size()), 65'(0));
    // mtimecmp programming with the comparator asserted
    set_mode(0);
    mtime_ge_i = 1'b1;
    step();
    exp_wr.push_back({CMP_LO_A, 32'hFFFF_FFFF});
    exp_wr.push_back({CMP_HI_A, 32'h0000_0002});
    exp_wr.push_back({CMP_LO_A, 32'h1234_5678});
    exp_rsp.push_back(65'(0));
`ifdef CLINT_TIMER_IRQ_MASK_EN
    irq_exp = 1'b0;
`else
    irq_exp = 1'b1;
`endif
    irq_chk = 1'b1;
    do_cmd(2'(CMD_WR_CMP), 64'h0000_0002_1234_5678, 1'b0);
    wait_rsp();
    irq_chk = 1'b0;
    chk("wr_cmp_lat", 65'(rsp_cyc - acc_cyc), 65'(4));
    step();
    chk("irq_after", 65'(timer_irq_o), 65'(1));
    mtime_ge_i = 1'b0;
    step();
    chk("irq_low", 65'(timer_irq_o), 65'(0));
    exp_rd.push_back(CMP_LO_A); exp_rd.push_back(CMP_HI_A);
    exp_rsp.push_back({1'b0, 64'h0000_0002_1234_5678});
    do_cmd(2'(CMD_RD_CMP), 64'd0, 1'b0);
    wait_rsp();
    chk("rd_cmp_lat", 65'(rsp_cyc - acc_cyc), 65'(3));
    // mtime load with cmd_valid_i held through the sequence
    for (int k = 0; k < 2; k++) begin
      exp_wr.push_back({MTIME_LO_A, 32'd0});
      exp_wr.push_back({MTIME_HI_A, 32'd1});
      exp_wr.push_back({MTIME_LO_A, 32'd0});
      exp_rsp.push_back(65'(0));
    end
    do_cmd(2'(CMD_WR_TIME), 64'h1_0000_0000, 1'b1);
    chk("busy_ready1", 65'(cmd_ready_o), 65'(0));
    for (int i = 0; i < 3; i++) begin
      step();
      chk("busy_ready", 65'(cmd_ready_o), 65'(0));
    end
    chk("wr_time_rsp", 65'(nrsp), 65'(6));
    chk("wr_time_lat", 65'(rsp_cyc - acc_cyc), 65'(4));
    do_cmd(2'(CMD_WR_TIME), 64'h1_0000_0000, 1'b0);
    wait_rsp();
    chk("wr_left", 65'(exp_wr.size()), 65'(0));
    exp_rd.push_back(MTIME_HI_A); exp_rd.push_back(MTIME_LO_A); exp_rd.push_back(MTIME_HI_A);
    exp_rsp.push_back({1'b0, 64'h1_0000_0000});
    do_cmd(2'(CMD_RD_TIME), 64'd0, 1'b0);
    wait_rsp();
    step();
    chk("rsp_left", 65'(exp_rsp.size()), 65'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/clint_timer_master.md
Name: clint_timer_master

Overview:
- Bus initiator that drives the 32-bit mtime/mtimecmp register port: address, write valid, write data and combinational read data.
- Turns core-side 64-bit timer commands into ordered 32-bit sequences:
  - coherent read of mtime;
  - glitch-free programming of mtimecmp;
  - loading of mtime.
- Sits between the CSR/LSU MMIO path and the mtime peripheral. Also conditions the timer-interrupt level sent to the CSR unit.

Parameters:
- MAX_RETRY, 3: extra high-word re-reads allowed in a coherent mtime read before it gives up with an error.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous, active-high reset
- cmd_valid_i  input  1  command request
- cmd_ready_o  output  1  high only in IDLE
- cmd_op_i  input  2  0=RD_TIME, 1=WR_CMP, 2=WR_TIME, 3=RD_CMP
- cmd_wdata_i  input  64  write payload, sampled at accept
- rsp_valid_o  output  1  one-cycle response pulse
- rsp_rdata_o  output  64  read result; 0 for writes
- rsp_err_o  output  1  retry limit exceeded
- bus_addr_o  output  32  one of `MTIME_ADDR_LOW/HIGH, `MTIMECMP_ADDR_LOW/HIGH; 0 when idle
- bus_write_valid_o  output  1  write strobe for the current beat
- bus_wdata_o  output  32  write data
- bus_rdata_i  input  32  read data, valid in the same cycle as bus_addr_o
- mtime_ge_i  input  1  comparator result from the timer
- timer_irq_o  output  1  interrupt level to the CSR unit

Behaviour:
Reset values:
- All outputs are 0 and the state is IDLE.
- Capture registers are cleared.
- Reset mid-sequence aborts with no response and no further bus beats.

Command acceptance and bus beats:
- A command is accepted when cmd_valid_i and cmd_ready_o are both high. cmd_wdata_i and cmd_op_i are latched in that cycle.
- Exactly one bus beat is issued per FSM state. All bus outputs are registered-state decoded, i.e. a function of state only.
- A read beat captures bus_rdata_i at the clock edge ending that beat.

States and sequences:
- IDLE
- RD_TIME: RT_HI1 -> RT_LO -> RT_HI2
  - RT_HI1 captures hi1. RT_LO captures lo. RT_HI2 compares bus_rdata_i with hi1.
  - If equal: the response is {hi1, lo}, with err=0.
  - If not equal and retries < MAX_RETRY: hi1 <= bus_rdata_i, retries++, go to RT_LO.
  - If not equal and retries == MAX_RETRY: respond {bus_rdata_i, lo} with err=1.
- RD_CMP: RC_LO -> RC_HI. mtimecmp is static, so no retry is needed.
- WR_CMP: WC_LO_MAX -> WC_HI -> WC_LO
  - WC_LO_MAX writes 0xFFFF_FFFF to the mtimecmp low word.
  - WC_HI writes wdata[63:32].
  - WC_LO writes wdata[31:0].
- WR_TIME: WT_LO0 -> WT_HI -> WT_LO
  - WT_LO0 writes 0 to the mtime low word. This prevents a carry into the high word mid-update.
  - WT_HI then writes the high half; WT_LO writes the low half.
- RESP: rsp_valid_o=1 for one cycle, then IDLE.
  - rsp_rdata_o/rsp_err_o hold their values until the next response.
  - No backpressure: the requester must accept the pulse.

Latency (accept to rsp_valid, inclusive of RESP):
- RD_TIME: 4 cycles without retry, +1 per retry.
- RD_CMP: 3 cycles.
- WR_CMP and WR_TIME: 4 cycles.

Other rules:
- cmd_valid_i while busy is ignored; the command stays pending until accepted.
- bus_write_valid_o is never high on a read beat.

Optional Feature:
- Macro: CLINT_TIMER_IRQ_MASK_EN
- Defined:
  - timer_irq_o is a registered mtime_ge_i, forced to 0 while in WC_LO_MAX, WC_HI, WC_LO, and for the first cycle after WC_LO. This suppresses spurious interrupts caused by a partially written compare value.
  - IRQ latency is 1 cycle.
- Undefined: timer_irq_o = mtime_ge_i, combinational pass-through.

Decomposition:
- Shared package/header holds:
  - the command opcode constants CMD_RD_TIME, CMD_WR_CMP, CMD_WR_TIME, CMD_RD_CMP;
  - the FSM state encodings;
  - the existing address macros from sysconfig.v.
- No sub-module; a single FSM plus datapath is natural.

Test Plan:
- Reset mid-WR_CMP (asserted during WC_HI) -> no rsp_valid, bus_write_valid_o=0 the next cycle, cmd_ready_o=1 after reset deasserts.
- RD_TIME with the model mtime at 0x0000_0005_0000_1000 (no carry) -> addr sequence HIGH, LOW, HIGH; rsp_rdata=0x0000_0005_0000_1000, err=0, rsp 4 cycles after accept.
- RD_TIME with the model low word at 0xFFFF_FFFE and the high word rolling from 7 to 8 between beats -> one retry; response has high word 8 and the low word from the retry; err=0.
- RD_TIME with a model whose high word changes on every read and MAX_RETRY=3 -> 3 retries, then rsp_err=1.
- WR_CMP 0x0000_0002_1234_5678 -> beats: CMP_LOW<=0xFFFFFFFF, CMP_HIGH<=0x2, CMP_LOW<=0x12345678; with the macro defined, timer_irq_o=0 throughout even while mtime_ge_i=1. A subsequent RD_CMP returns the written value.
- WR_TIME 0x1_0000_0000 -> beats: MTIME_LOW<=0, MTIME_HIGH<=1, MTIME_LOW<=0; cmd_valid_i held high during the sequence is not accepted until after RESP.
